// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI slave endpoint.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int unsigned MIN_CLK_RATIO = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus a delay flop for edge detection on an async SPI pin.
module spi_sync_edge #(
    parameter logic p_rst = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= p_rst;
            sync <= p_rst;
            dly  <= p_rst;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/spi_slave_if.sv
// Oversampled SPI slave: receives words on mosi, returns tx_data_i on miso.
// Optional frame error output enabled by SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned p_clkfreq  = 100_000_000,
    parameter int unsigned p_sclkfreq = 1_000_000,
    parameter logic        p_cpol     = 1'b0,
    parameter logic        p_cpha     = 1'b0,
    parameter int unsigned p_width    = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cs_i,
    input  logic               sclk_i,
    input  logic               mosi_i,
    output logic               miso_o,
    input  logic [p_width-1:0] tx_data_i,
    output logic [p_width-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               busy_o
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic               frame_err_o
`endif
);

    localparam int unsigned     CW   = $clog2(p_width + 1);
    localparam logic [CW-1:0]   LAST = CW'(p_width - 1);

    if (p_clkfreq / p_sclkfreq < MIN_CLK_RATIO) begin : g_ratio_check
        $error("spi_slave_if: system clock must be at least 8x sclk");
    end

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_meta, mosi_sync;
    logic unused_sync;

    spi_sync_edge #(.p_rst(1'b1)) u_cs_sync (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .din   (cs_i),
        .sync  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.p_rst(p_cpol)) u_sclk_sync (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .din   (sclk_i),
        .sync  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    assign unused_sync = cs_sync ^ sclk_sync;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= mosi_i;
            mosi_sync <= mosi_meta;
        end
    end

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = p_cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = p_cpol ? sclk_rise : sclk_fall;
    assign sample_edge = p_cpha ? trail_edge : lead_edge;
    assign shift_edge  = p_cpha ? lead_edge  : trail_edge;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [p_width-2:0] rx_shift;
    logic [p_width-1:0] tx_shift;
    logic [p_width-1:0] rx_word;
    logic               reload;
    logic               hold;

    assign rx_word = {rx_shift, mosi_sync};

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic fresh;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            reload     <= 1'b0;
            hold       <= 1'b0;
            miso_o     <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_o <= 1'b0;
            fresh       <= 1'b0;
`endif
        end else begin
            rx_valid_o <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_o <= 1'b0;
            fresh       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    miso_o <= 1'b0;
                    busy_o <= 1'b0;
                    if (cs_fall) begin
                        tx_shift <= tx_data_i;
                        miso_o   <= tx_data_i[p_width-1];
                        cnt      <= '0;
                        reload   <= 1'b0;
                        hold     <= p_cpha;
                        busy_o   <= 1'b1;
                        state    <= ACTIVE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        fresh <= 1'b1;
                        if (sclk_rise || sclk_fall) frame_err_o <= 1'b1;
`endif
                    end
                end
                ACTIVE: begin
                    busy_o <= 1'b1;
                    if (sample_edge) begin
                        rx_shift <= rx_word[p_width-2:0];
                        if (cnt == LAST) begin
                            rx_data_o  <= rx_word;
                            rx_valid_o <= 1'b1;
                            cnt        <= '0;
                            reload     <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    // Next word is loaded on the shift edge that presents its MSB,
                    // so local logic may update tx_data_i after seeing rx_valid_o.
                    if (shift_edge) begin
                        if (reload) begin
                            tx_shift <= tx_data_i;
                            miso_o   <= tx_data_i[p_width-1];
                            reload   <= 1'b0;
                        end else if (hold) begin
                            miso_o <= tx_shift[p_width-1];
                            hold   <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[p_width-2:0], 1'b0};
                            miso_o   <= tx_shift[p_width-2];
                        end
                    end
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    if (fresh && (sclk_rise || sclk_fall)) frame_err_o <= 1'b1;
`endif
                    if (cs_rise) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        miso_o <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        if (sample_edge ? (cnt != LAST) : (cnt != '0)) frame_err_o <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Clock-domain SPI slave endpoint that sits on the far end of the bus driven by spi_master.
- Consumes cs/sclk/mosi, produces miso.
- Hands each received byte to local logic and takes the next byte to return.
- Oversamples the SPI pins with the system clock; no logic is clocked by sclk.

Parameters:
- p_clkfreq, 100_000_000, system clock frequency in Hz; informational only, used for the sclk ratio check.
- p_sclkfreq, 1_000_000, maximum sclk frequency in Hz; p_clkfreq/p_sclkfreq must be >= 8.
- p_cpol, 0, sclk idle level.
- p_cpha, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- p_width, 8, bits per word.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cs_i  in  1  chip select, active low, asynchronous to clk_i
- sclk_i  in  1  serial clock, asynchronous
- mosi_i  in  1  serial data in, asynchronous
- miso_o  out  1  serial data out
- tx_data_i  in  p_width  word to return; latched at frame start and at each word boundary
- rx_data_o  out  p_width  last complete received word; holds until the next word completes
- rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
- busy_o  out  1  high while the frame is active

Behaviour:
- Reset (rstn_i low, asynchronous):
  - miso_o=0, rx_data_o=0, rx_valid_o=0, busy_o=0.
  - Bit counter=0, shift registers=0, FSM=IDLE.
  - Synchronizers load their idle values: cs=1, sclk=p_cpol.
- Input sync:
  - cs_i, sclk_i and mosi_i each pass through a 2-flop synchronizer.
  - A third flop on cs and sclk provides edge detection.
  - Leading edge = rising if p_cpol=0, falling if p_cpol=1.
  - sample_edge = leading if p_cpha=0, else trailing; shift_edge = the other edge.
- FSM IDLE:
  - miso_o=0, busy_o=0.
  - On synchronized cs falling edge: latch tx_data_i into tx_shift, drive miso_o=MSB, clear the bit counter, go to ACTIVE.
- FSM ACTIVE:
  - busy_o=1.
  - On sample_edge: rx_shift <= {rx_shift[p_width-2:0], mosi_sync}, counter++.
  - On shift_edge: tx_shift shifts left and miso_o <= new MSB.
    - If p_cpha=1, the first shift_edge (the leading edge) presents the MSB instead of shifting.
  - On the sample that makes counter==p_width:
    - rx_data_o <= completed word and rx_valid_o pulses the next cycle.
    - Counter <= 0, tx_shift <= tx_data_i (multi-word frames supported).
  - Synchronized cs rising edge → IDLE; a partial word is discarded with no rx_valid_o.
- Latency: rx_valid_o asserts at most 4 clk_i after the physical final sample edge (2 sync + edge detect + register).
- Simultaneous cs rise and final sample edge in the same clk_i: the sample completes and rx_valid_o fires, then IDLE.
- Glitch tolerance: sclk edges while cs is high are ignored.
- Reset mid-frame: immediate abort, no rx_valid_o, the frame resumes only after a fresh cs fall.
- Counter width: $clog2(p_width+1), wraps to 0 at each word boundary.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err_o (1 bit, reset 0).
  - Pulses one cycle when the synchronized cs rises with bit counter != 0, i.e. a truncated word.
  - Also pulses when sclk is seen toggling within 1 clk_i of cs fall (setup violation).
- Undefined: port absent, truncated words are silently discarded.

Decomposition:
- Package spi_pkg holds:
  - localparams for mode encodings (MODE0..MODE3 as {cpol,cpha});
  - the FSM state typedef/encoding (IDLE=1'b0, ACTIVE=1'b1);
  - the minimum clock ratio constant 8.
- Sub-module spi_sync_edge:
  - 2-flop synchronizer plus a delay flop, outputs sync/rise/fall;
  - reset value set by parameter;
  - instantiated for cs and sclk.
- mosi uses a plain 2-flop synchronizer.

Test Plan:
- Mode 0, bench-driven master sends 0xD2 and tx_data_i=0xA2 → rx_data_o=0xD2 with a single rx_valid_o pulse; miso bits captured by the master = 0xA2.
- Mode 0, one cs frame carrying 0x81 then 0xC2, tx_data_i changed from 0x18 to 0x5A after the first rx_valid_o → two pulses, rx_data_o 0x81 then 0xC2; miso returns 0x18 then 0x5A.
- Mode 3 (cpol=1, cpha=1), send 0x3C, tx 0xF0 → rx_data_o=0x3C, miso=0xF0, sclk idles high throughout.
- cs deasserted after 5 bits of 0xFF → no rx_valid_o, rx_data_o unchanged, busy_o drops within 3 clk_i. With SPI_SLAVE_FRAME_ERR_EN, frame_err_o pulses once.
- rstn_i pulsed low after bit 3 of a frame → all outputs 0 immediately. The next full frame of 0x55 yields rx_data_o=0x55.
- sclk toggled 8 times while cs_i high → no rx_valid_o, miso_o stays 0.
